// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: MDU op encodings,
// MDU sequencer states and the register-address width.
package mips_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] MDU_OP_NONE = 2'b00;
    localparam logic [1:0] MDU_OP_MUL  = 2'b01;
    localparam logic [1:0] MDU_OP_DIV  = 2'b10;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_MUL,
        MDU_DIV,
        MDU_DONE
    } mdu_state_e;

    // True when a producer's destination is a register the ID instruction reads; $0 never matches.
    function automatic logic reg_hit(
        input logic [REG_ADDR_W-1:0] dst,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rt,
        input logic                  use_rs,
        input logic                  use_rt
    );
        return (dst != '0) && ((use_rs && (rs == dst)) || (use_rt && (rt == dst)));
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// Multiply/divide unit sequencer: counts out the operation latency and produces
// the start strobe, the busy flag and the HI/LO write strobe.
import mips_pkg::*;

module mdu_seq #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mdu_op,
    input  logic       mem_wait,
    output logic       mdu_start,
    output logic       mdu_busy,
    output logic       hilo_we
);

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             hilo_we_q, hilo_we_d;

    // The EX op only launches when EX is free to advance, i.e. not held by a memory wait.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_start = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (!mem_wait && (mdu_op == MDU_OP_MUL)) begin
                    mdu_start = 1'b1;
                    cnt_d     = CNT_W'(MUL_CYCLES - 1);
                    state_d   = MDU_MUL;
                end else if (!mem_wait && (mdu_op == MDU_OP_DIV)) begin
                    mdu_start = 1'b1;
                    cnt_d     = CNT_W'(DIV_CYCLES - 1);
                    state_d   = MDU_DIV;
                end
            end
            MDU_MUL, MDU_DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
        busy_d    = (state_d != MDU_IDLE);
        hilo_we_d = (state_d == MDU_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hilo_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hilo_we_q <= hilo_we_d;
        end
    end

    assign mdu_busy = busy_q;
    assign hilo_we  = hilo_we_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: resolves load-use,
// branch-operand, MDU structural and memory-wait hazards, and counts stall cycles.
import mips_pkg::*;

module hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rsAddr_id,
    input  logic [REG_ADDR_W-1:0] rtAddr_id,
    input  logic                  useRs_id,
    input  logic                  useRt_id,
    input  logic                  Branch_id,
    input  logic                  branch_taken_id,
    input  logic                  mdu_read_id,
    input  logic                  MemRead_ex,
    input  logic                  RegWrite_ex,
    input  logic [REG_ADDR_W-1:0] RegWriteAddr_ex,
    input  logic [1:0]            mdu_op_ex,
    input  logic                  MemRead_mem,
    input  logic [REG_ADDR_W-1:0] RegWriteAddr_mem,
    input  logic                  dmem_req_mem,
    input  logic                  dmem_ready_mem,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  stall_mem,
    output logic                  bubble_ex,
    output logic                  bubble_mem,
    output logic                  bubble_wb,
    output logic                  flush_id,
    output logic                  mdu_start,
    output logic                  mdu_busy,
    output logic                  hilo_we,
    output logic [31:0]           stall_cycles
);

    logic        mem_wait;
    logic        mdu_op_valid;
    logic        mdu_hz;
    logic        hit_ex;
    logic        hit_mem;
    logic        id_hz;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    mdu_seq #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_mdu_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdu_op   (mdu_op_ex),
        .mem_wait (mem_wait),
        .mdu_start(mdu_start),
        .mdu_busy (mdu_busy),
        .hilo_we  (hilo_we)
    );

    // mdu_busy is registered from the sequencer's next state, so it is exactly "state != IDLE".
    assign mem_wait     = dmem_req_mem && !dmem_ready_mem;
    assign mdu_op_valid = (mdu_op_ex == MDU_OP_MUL) || (mdu_op_ex == MDU_OP_DIV);
    assign mdu_hz       = mdu_busy && (mdu_op_valid || mdu_read_id);
    assign hit_ex       = reg_hit(RegWriteAddr_ex, rsAddr_id, rtAddr_id, useRs_id, useRt_id);
    assign hit_mem      = reg_hit(RegWriteAddr_mem, rsAddr_id, rtAddr_id, useRs_id, useRt_id);
    assign id_hz        = (MemRead_ex && hit_ex)
                        || (Branch_id && RegWrite_ex && !MemRead_ex && hit_ex)
                        || (Branch_id && MemRead_mem && hit_mem);

    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        stall_mem  = 1'b0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        bubble_wb  = 1'b0;
        flush_id   = 1'b0;
        if (mem_wait) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            bubble_wb = 1'b1;
        end else if (mdu_hz) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
        end else if (id_hz) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (branch_taken_id && Branch_id) begin
            flush_id = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_if) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rsAddr_id, rtAddr_id, RegWriteAddr_ex, RegWriteAddr_mem;
    logic        useRs_id, useRt_id, Branch_id, branch_taken_id, mdu_read_id;
    logic        MemRead_ex, RegWrite_ex, MemRead_mem, dmem_req_mem, dmem_ready_mem;
    logic [1:0]  mdu_op_ex;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        bubble_ex, bubble_mem, bubble_wb, flush_id;
    logic        mdu_start, mdu_busy, hilo_we;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad = 0;

    // Model state: absolute cycle numbers of the last MDU launch and its latency.
    int          cyc = 0;
    int          start_cyc = -1000;
    int          lat = 0;
    int unsigned stall_cnt = 0;

    hazard_ctrl #(
        .MUL_CYCLES(MUL_LAT),
        .DIV_CYCLES(DIV_LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rsAddr_id       (rsAddr_id),
        .rtAddr_id       (rtAddr_id),
        .useRs_id        (useRs_id),
        .useRt_id        (useRt_id),
        .Branch_id       (Branch_id),
        .branch_taken_id (branch_taken_id),
        .mdu_read_id     (mdu_read_id),
        .MemRead_ex      (MemRead_ex),
        .RegWrite_ex     (RegWrite_ex),
        .RegWriteAddr_ex (RegWriteAddr_ex),
        .mdu_op_ex       (mdu_op_ex),
        .MemRead_mem     (MemRead_mem),
        .RegWriteAddr_mem(RegWriteAddr_mem),
        .dmem_req_mem    (dmem_req_mem),
        .dmem_ready_mem  (dmem_ready_mem),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .stall_ex        (stall_ex),
        .stall_mem       (stall_mem),
        .bubble_ex       (bubble_ex),
        .bubble_mem      (bubble_mem),
        .bubble_wb       (bubble_wb),
        .flush_id        (flush_id),
        .mdu_start       (mdu_start),
        .mdu_busy        (mdu_busy),
        .hilo_we         (hilo_we),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clearInputs();
        rsAddr_id = 5'd0; rtAddr_id = 5'd0; useRs_id = 1'b0; useRt_id = 1'b0;
        Branch_id = 1'b0; branch_taken_id = 1'b0; mdu_read_id = 1'b0;
        MemRead_ex = 1'b0; RegWrite_ex = 1'b0; RegWriteAddr_ex = 5'd0; mdu_op_ex = 2'd0;
        MemRead_mem = 1'b0; RegWriteAddr_mem = 5'd0;
        dmem_req_mem = 1'b0; dmem_ready_mem = 1'b1;
    endtask

    task automatic applyStimulus();
        rsAddr_id        = 5'($urandom_range(0, 3));
        rtAddr_id        = 5'($urandom_range(0, 3));
        RegWriteAddr_ex  = 5'($urandom_range(0, 3));
        RegWriteAddr_mem = 5'($urandom_range(0, 3));
        useRs_id         = 1'($urandom_range(0, 1));
        useRt_id         = 1'($urandom_range(0, 1));
        Branch_id        = ($urandom_range(0, 2) == 0);
        branch_taken_id  = 1'($urandom_range(0, 1));
        mdu_read_id      = ($urandom_range(0, 3) == 0);
        MemRead_ex       = ($urandom_range(0, 2) == 0);
        RegWrite_ex      = 1'($urandom_range(0, 1));
        MemRead_mem      = ($urandom_range(0, 2) == 0);
        dmem_req_mem     = 1'($urandom_range(0, 1));
        dmem_ready_mem   = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 15))
            0:       mdu_op_ex = 2'd1;
            1:       mdu_op_ex = 2'd2;
            2:       mdu_op_ex = 2'd3;
            default: mdu_op_ex = 2'd0;
        endcase
    endtask

    function automatic logic reads(input logic [4:0] a);
        return (a != 5'd0) && ((useRs_id && rsAddr_id == a) || (useRt_id && rtAddr_id == a));
    endfunction

    // Waits for the negative edge, compares every output with the model, then advances the model.
    task automatic evalCycle();
        logic active, done, opv, mw, mhz, idh, ex_start;
        logic si, sid, sex, smem, bex, bmem, bwb, fl;
        @(negedge clk);
        active = (cyc > start_cyc) && (cyc <= start_cyc + lat);
        done   = active && (cyc == start_cyc + lat);
        opv    = (mdu_op_ex == 2'd1) || (mdu_op_ex == 2'd2);
        mw     = dmem_req_mem && !dmem_ready_mem;
        mhz    = active && (opv || mdu_read_id);
        idh    = (MemRead_ex && reads(RegWriteAddr_ex))
              || (Branch_id && RegWrite_ex && !MemRead_ex && reads(RegWriteAddr_ex))
              || (Branch_id && MemRead_mem && reads(RegWriteAddr_mem));
        {si, sid, sex, smem, bex, bmem, bwb, fl} = 8'b0;
        if (mw)                              {si, sid, sex, smem, bwb} = 5'b11111;
        else if (mhz)                        {si, sid, sex, bmem} = 4'b1111;
        else if (idh)                        {si, sid, bex} = 3'b111;
        else if (Branch_id && branch_taken_id) fl = 1'b1;
        ex_start = !active && opv && !mw;
        checkOutput("ctrl",
            {21'd0, stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem,
             bubble_wb, flush_id, mdu_start, mdu_busy, hilo_we},
            {21'd0, si, sid, sex, smem, bex, bmem, bwb, fl, ex_start, active, done});
        checkOutput("stall_cycles", stall_cycles, stall_cnt);
        if (si) stall_cnt++;
        if (ex_start) begin
            start_cyc = cyc;
            lat = (mdu_op_ex == 2'd1) ? MUL_LAT : DIV_LAT;
        end
        cyc++;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        clearInputs();
        rst_n = 1'b0;
        #2;
        checkOutput("rst_busy", {31'd0, mdu_busy}, 32'd0);
        checkOutput("rst_hilo", {31'd0, hilo_we}, 32'd0);
        checkOutput("rst_cnt", stall_cycles, 32'd0);
        checkOutput("rst_ctrl", {24'd0, stall_if, stall_id, stall_ex, stall_mem,
                                  bubble_ex, bubble_mem, bubble_wb, flush_id}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_cyc = -1000;
        lat = 0;
        stall_cnt = 0;
    endtask

    task automatic setLoadUse8();
        MemRead_ex = 1'b1; RegWrite_ex = 1'b1; RegWriteAddr_ex = 5'd8;
        rsAddr_id = 5'd8; useRs_id = 1'b1;
    endtask

    initial begin
        clearInputs();
        doReset();

        // Load-use: one stall cycle, then the add proceeds.
        clearInputs(); setLoadUse8();
        evalCycle();
        checkOutput("lu_stall", {29'd0, stall_if, stall_id, bubble_ex}, 32'd7);
        checkOutput("lu_ex_free", {30'd0, stall_ex, stall_mem}, 32'd0);
        nextCycle();
        clearInputs(); rsAddr_id = 5'd8; useRs_id = 1'b1; MemRead_mem = 1'b1; RegWriteAddr_mem = 5'd8;
        evalCycle();
        checkOutput("lu_release", {31'd0, stall_if}, 32'd0);
        checkOutput("lu_count", stall_cycles, 32'd1);
        nextCycle();

        // Taken beq on a load: stalls in EX then MEM, flushes once clear.
        doReset();
        clearInputs(); MemRead_ex = 1'b1; RegWrite_ex = 1'b1; RegWriteAddr_ex = 5'd9;
        Branch_id = 1'b1; branch_taken_id = 1'b1; rtAddr_id = 5'd9; useRt_id = 1'b1;
        evalCycle();
        checkOutput("brld_stall1", {30'd0, stall_if, flush_id}, 32'd2);
        nextCycle();
        MemRead_ex = 1'b0; RegWrite_ex = 1'b0; RegWriteAddr_ex = 5'd0;
        MemRead_mem = 1'b1; RegWriteAddr_mem = 5'd9;
        evalCycle();
        checkOutput("brld_stall2", {30'd0, stall_if, flush_id}, 32'd2);
        nextCycle();
        MemRead_mem = 1'b0; RegWriteAddr_mem = 5'd0;
        evalCycle();
        checkOutput("brld_flush", {30'd0, stall_if, flush_id}, 32'd1);
        checkOutput("brld_count", stall_cycles, 32'd2);
        nextCycle();

        // Divide followed by mfhi: held until HI/LO is written.
        doReset();
        clearInputs(); mdu_op_ex = 2'd2;
        evalCycle();
        checkOutput("div_start", {30'd0, mdu_start, stall_if}, 32'd2);
        nextCycle();
        for (int k = 1; k <= DIV_LAT; k++) begin
            clearInputs(); mdu_read_id = 1'b1;
            evalCycle();
            if (k == 1) checkOutput("div_busy1", {28'd0, mdu_busy, stall_if, stall_ex, bubble_mem}, 32'hF);
            if (k == DIV_LAT - 1) checkOutput("div_hilo_early", {31'd0, hilo_we}, 32'd0);
            if (k == DIV_LAT) checkOutput("div_hilo", {29'd0, hilo_we, mdu_busy, stall_if}, 32'd7);
            nextCycle();
        end
        clearInputs(); mdu_read_id = 1'b1;
        evalCycle();
        checkOutput("div_release", {29'd0, stall_if, mdu_busy, hilo_we}, 32'd0);
        checkOutput("div_count", stall_cycles, 32'd32);
        nextCycle();

        // Memory wait on top of a load-use hazard.
        doReset();
        for (int k = 0; k < 3; k++) begin
            clearInputs(); setLoadUse8(); dmem_req_mem = 1'b1; dmem_ready_mem = 1'b0;
            evalCycle();
            checkOutput("mw_ctrl", {26'd0, stall_if, stall_id, stall_ex, stall_mem, bubble_wb, bubble_ex}, 32'h3E);
            nextCycle();
        end
        clearInputs(); setLoadUse8(); dmem_req_mem = 1'b1;
        evalCycle();
        checkOutput("mw_then_lu", {26'd0, stall_if, stall_id, stall_ex, stall_mem, bubble_wb, bubble_ex}, 32'h31);
        nextCycle();
        clearInputs();
        evalCycle();
        checkOutput("mw_count", stall_cycles, 32'd4);
        nextCycle();

        // Reset in the middle of a multiply.
        doReset();
        clearInputs(); mdu_op_ex = 2'd1;
        evalCycle();
        checkOutput("mul_start", {31'd0, mdu_start}, 32'd1);
        nextCycle();
        clearInputs();
        evalCycle();
        nextCycle();
        clearInputs(); mdu_read_id = 1'b1;
        evalCycle();
        checkOutput("mul_busy", {30'd0, mdu_busy, stall_if}, 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {30'd0, mdu_busy, hilo_we}, 32'd0);
        checkOutput("abort_cnt", stall_cycles, 32'd0);
        checkOutput("abort_stall", {31'd0, stall_if}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            checkOutput("abort_no_hilo", {31'd0, hilo_we}, 32'd0);
        end
        doReset();

        // $0 never produces a hazard.
        clearInputs(); MemRead_ex = 1'b1; RegWrite_ex = 1'b1; useRs_id = 1'b1;
        Branch_id = 1'b1; useRt_id = 1'b1; MemRead_mem = 1'b1;
        evalCycle();
        checkOutput("r0_nostall", {31'd0, stall_if}, 32'd0);
        nextCycle();

        // Randomized traffic against the model.
        doReset();
        for (int k = 0; k < 3000; k++) begin
            applyStimulus();
            evalCycle();
            nextCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
